bin2bcd_seq: RTL and testbench

- Iterative binary-to-BCD converter using double-dabble (shift-and-add-3).
- Sits directly upstream of the seven-segment display driver, which consumes a 20-bit word of five hex nibbles.
- Turns a 16-bit unsigned sensor reading from the I2C master path into five packed BCD digits, so the display shows decimal.
- The result is held stable between conversions, so the display never shows partial values.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bcd_digit_adj.sv | 8 +
 rtl/bin2bcd_seq.sv | 81 ++++++++
 tb/tb_bin2bcd_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
// Holds default widths, FSM encoding and the digit-sufficiency check.
package bcd_pkg;

  localparam int BIN_W_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_ok(int bin_w, int digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10   = 1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 10;
    max_bin = (64'd1 << bin_w) - 64'd1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the converter and its producer/consumer.
// The converter takes the slave side; whoever drives in_bin takes master.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_valid;
  logic                  busy;

  modport master (
    output in_valid, in_bin,
    input  in_ready, out_bcd, out_valid, busy
  );

  modport slave (
    input  in_valid, in_bin,
    output in_ready, out_bcd, out_valid, busy
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Inputs 5..9 land on 8..12, so the 4-bit result never wraps.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-and-add-3 step per clock.
// out_bcd only moves on the out_valid edge, so the display never sees partial digits.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (!digits_ok(BIN_W, DIGITS)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small to represent 2**BIN_W-1");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   out_bcd_q;
  logic               out_valid_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  // All digits corrected in parallel, then the combined register shifts left once.
  assign {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      out_bcd_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            bin_q   <= bus.in_bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            out_bcd_q   <= bcd_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, boundaries, back-to-back, reset abort, random sweep.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   pulses;
  int   accepts;
  int   cyc;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && bus.in_valid && bus.in_ready) accepts <= accepts + 1;
  end

  always @(negedge clk) if (bus.out_valid) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Issue one value, measure edges from accept to out_valid, check result and pulse width.
  task automatic convert(input string tag, input logic [15:0] v, input logic [31:0] exp);
    int edges;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_bin   = v;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bin   = ~v;
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_lat"}, 32'(edges), 32'd16);
    chk({tag, "_bcd"}, 32'(bus.out_bcd), exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int p0;
    int a0;
    int idx;
    int last;
    logic [31:0] exp_seq [1:3];
    logic [15:0] rv;

    checks = 0; errors = 0; pulses = 0; accepts = 0; cyc = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bin   = '0;
    #1;
    chk("rst_async_bcd", 32'(bus.out_bcd), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_bcd",   32'(bus.out_bcd),   32'h0);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_vld",   32'(bus.out_valid), 32'd0);

    p0 = pulses;
    convert("zero", 16'd0, 32'h00000);
    chk("zero_pulses", 32'(pulses - p0), 32'd1);

    convert("v12345", 16'd12345, 32'h12345);
    p0 = pulses;
    repeat (100) @(negedge clk);
    chk("hold_bcd",    32'(bus.out_bcd), 32'h12345);
    chk("hold_pulses", 32'(pulses - p0), 32'd0);

    convert("v9",     16'd9,     32'h00009);
    convert("v10",    16'd10,    32'h00010);
    convert("v99",    16'd99,    32'h00099);
    convert("v100",   16'd100,   32'h00100);
    convert("v65535", 16'd65535, 32'h65535);

    // Back-to-back: in_valid stays high, in_bin scrambled whenever busy.
    exp_seq[1] = 32'h00001; exp_seq[2] = 32'h00002; exp_seq[3] = 32'h00003;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = 16'd1;
    idx  = 1;
    last = -1;
    for (int n = 0; n < 120 && idx < 4; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk($sformatf("b2b_bcd%0d", idx), 32'(bus.out_bcd), exp_seq[idx]);
        if (last >= 0) chk($sformatf("b2b_gap%0d", idx), 32'(cyc - last), 32'd17);
        last = cyc;
        idx++;
        if (idx == 4) bus.in_valid = 1'b0;
        bus.in_bin = 16'(idx);
      end else if (!bus.in_ready) begin
        bus.in_bin = 16'(16'hBEEF ^ 16'(n));
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_count", 32'(idx), 32'd4);

    // Reset mid-conversion aborts and clears the held result.
    @(negedge clk);
    p0 = pulses;
    bus.in_valid = 1'b1;
    bus.in_bin   = 16'd4321;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_bcd",   32'(bus.out_bcd),   32'h0);
    chk("abort_ready", 32'(bus.in_ready),  32'd1);
    chk("abort_vld",   32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_pulses", 32'(pulses - p0), 32'd0);
    chk("abort_hold",   32'(bus.out_bcd), 32'h0);
    convert("v4321", 16'd4321, 32'h04321);

    // Random sweep against a divide-by-ten reference.
    p0 = pulses;
    a0 = accepts;
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      convert("rand", rv, ref_bcd(32'(rv)));
    end
    @(negedge clk);
    chk("rand_counts", 32'(pulses - p0), 32'(accepts - a0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
